// File: rtl/pipeline_result_collector.sv
// Re-times the operand-valid strobe to the pipeline output, buffers captured F values
// in a small FIFO with valid/ready, and keeps running sum, count and sticky overflow.
module pipeline_result_collector #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [N-1:0]               f_in,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [ACC_W-1:0]           acc,
  output logic [CNT_W-1:0]           res_cnt,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [LAT-1:0] vsr;
  logic [N-1:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           cap;
  logic           rd;
  logic           wr;
  logic           drop;

  assign cap       = vsr[LAT-1];
  assign full      = (count == LVL_FULL);
  assign out_valid = (count != '0);
  assign level     = count;
  assign out_data  = mem[rd_ptr];
  assign rd        = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a capture into a full FIFO still lands.
  assign wr        = cap && (!full || rd);
  assign drop      = cap && full && !rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr <= '0;
    end else begin
      vsr[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        vsr[i] <= vsr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= f_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr, rd})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // clear restarts the statistics but still counts a write landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      res_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear) begin
        acc     <= wr ? {{(ACC_W-N){1'b0}}, f_in} : '0;
        res_cnt <= wr ? CNT_W'(1) : '0;
      end else if (wr) begin
        acc     <= acc + {{(ACC_W-N){1'b0}}, f_in};
        res_cnt <= res_cnt + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Directed bench: drives f_in with hand-computed pipeline results at the capture edge.
module tb_pipeline_result_collector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  f_in;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic [2:0]  level;
  logic        full;
  logic [15:0] acc;
  logic [7:0]  res_cnt;
  logic        overflow;

  int checks;
  int failures;

  pipeline_result_collector #(
    .N(10), .LAT(3), .DEPTH(4), .ACC_W(16), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .f_in      (f_in),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .acc       (acc),
    .res_cnt   (res_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"},  32'(out_data),  0);
    check({tag, "_level"},     32'(level),     0);
    check({tag, "_full"},      32'(full),      0);
    check({tag, "_acc"},       32'(acc),       0);
    check({tag, "_res_cnt"},   32'(res_cnt),   0);
    check({tag, "_overflow"},  32'(overflow),  0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    f_in      = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single result: A=10,B=12,C=11,D=3 -> (22+8)*3 = 90
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    f_in = 10'd90;
    tick();
    tick();
    check("single_early_valid", 32'(out_valid), 0);
    tick();
    check("single_valid",   32'(out_valid), 1);
    check("single_data",    32'(out_data),  90);
    check("single_level",   32'(level),     1);
    check("single_acc",     32'(acc),       90);
    check("single_res_cnt", 32'(res_cnt),   1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drain_level", 32'(level), 0);
    do_clear();
    check("clear_acc", 32'(acc), 0);
    check("clear_cnt", 32'(res_cnt), 0);

    // Back-to-back: 90 then (19+21)*8 = 320
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    f_in = 10'd90;
    tick();
    check("b2b_first",       32'(out_data), 90);
    check("b2b_first_level", 32'(level),    1);
    f_in = 10'd320;
    tick();
    check("b2b_second",       32'(out_data), 320);
    check("b2b_second_level", 32'(level),    1);
    f_in = '0;
    tick();
    check("b2b_acc",   32'(acc),       410);
    check("b2b_cnt",   32'(res_cnt),   2);
    check("b2b_level", 32'(level),     0);
    check("b2b_valid", 32'(out_valid), 0);

    // Fill 1..4, fifth capture dropped
    out_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 5);
      f_in = (i >= 3) ? 10'(i - 2) : 10'd0;
      tick();
      if (i == 6) begin
        check("fill_full_4th",    32'(full),     1);
        check("fill_no_ovf_yet",  32'(overflow), 0);
      end
    end
    check("fill_level",    32'(level),    4);
    check("fill_overflow", 32'(overflow), 1);
    check("fill_acc",      32'(acc),      10);
    check("fill_cnt",      32'(res_cnt),  4);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_data",  32'(out_data),  32'(k));
      tick();
    end
    check("drain_empty", 32'(out_valid), 0);
    tick();
    check("empty_ready_no_underflow", 32'(level), 0);
    out_ready = 1'b0;

    // Full with simultaneous pop and capture of 7
    do_clear();
    check("clear_overflow", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      in_valid  = (i < 5);
      f_in      = (i == 7) ? 10'd7 : ((i >= 3) ? 10'(i - 2) : 10'd0);
      out_ready = (i == 7);
      tick();
    end
    out_ready = 1'b0;
    check("fullrd_level",    32'(level),    4);
    check("fullrd_overflow", 32'(overflow), 0);
    check("fullrd_acc",      32'(acc),      17);
    check("fullrd_cnt",      32'(res_cnt),  5);
    out_ready = 1'b1;
    check("fullrd_d0", 32'(out_data), 2); tick();
    check("fullrd_d1", 32'(out_data), 3); tick();
    check("fullrd_d2", 32'(out_data), 4); tick();
    check("fullrd_d3", 32'(out_data), 7); tick();
    out_ready = 1'b0;
    check("fullrd_empty", 32'(level), 0);

    // Clear coincident with a capture of 9, with acc=410 and overflow set
    do_clear();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 5);
      case (i)
        3, 4, 5: f_in = 10'd100;
        6:       f_in = 10'd110;
        7:       f_in = 10'd5;
        default: f_in = 10'd0;
      endcase
      tick();
    end
    check("pre_clear_acc", 32'(acc),      410);
    check("pre_clear_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    f_in  = 10'd9;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrwr_acc",   32'(acc),      9);
    check("clrwr_cnt",   32'(res_cnt),  1);
    check("clrwr_ovf",   32'(overflow), 0);
    check("clrwr_level", 32'(level),    4);
    check("clrwr_head",  32'(out_data), 100);

    // Clear coincident with a dropped capture: overflow set wins
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    f_in  = 10'd33;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrdrop_ovf", 32'(overflow), 1);
    check("clrdrop_acc", 32'(acc),      0);
    check("clrdrop_cnt", 32'(res_cnt),  0);
    out_ready = 1'b1;
    check("clr_d0", 32'(out_data), 100); tick();
    check("clr_d1", 32'(out_data), 100); tick();
    check("clr_d2", 32'(out_data), 110); tick();
    check("clr_d3", 32'(out_data), 9);   tick();
    out_ready = 1'b0;

    // Async reset mid-traffic: level=2 and two tags in flight
    do_clear();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      f_in     = 10'd55;
      tick();
    end
    in_valid = 1'b0;
    check("midrst_pre_level", 32'(level), 2);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check("midrst_no_capture_level", 32'(level),   0);
    check("midrst_no_capture_cnt",   32'(res_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
